// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes,
// opcode constants, datapath mux select codes and the control vector type.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every select and enable the datapath needs, in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'(16'h0000);

    // Loads and stores share the address-computation state.
    function automatic logic op_is_mem(input logic [5:0] op);
        logic hit_s;
        if ((op == OP_LW) || (op == OP_SW)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_control_if;

    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] State;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State
    );

endinterface

// File: rtl/multicycle_decode.sv
// Purely combinational Moore decode: state (plus MemReady in FETCH) to
// the full control vector. Unused state codes decode to all-zero.
module multicycle_decode
    import multicycle_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state control row; anything not set stays at zero.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // Qualified so a stalled fetch loads IR and bumps PC only once.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic, with
// the per-state control decode in multicycle_decode. Outputs are held at
// zero combinationally while reset is asserted.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    state_t state_r;
    state_t state_nxt_s;
    ctrl_t  ctrl_dec_s;
    ctrl_t  ctrl_out_s;

    // State register; reset returns to FETCH at once, mid-instruction or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection; Op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (bus.MemReady) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (bus.Op == OP_RTYPE) begin
                    state_nxt_s = S_EXEC;
                end else if (op_is_mem(bus.Op)) begin
                    state_nxt_s = S_MEMADR;
                end else if (bus.Op == OP_BEQ) begin
                    state_nxt_s = S_BRANCH;
                end else if (bus.Op == OP_J) begin
                    state_nxt_s = S_JUMP;
                end else begin
                    // Unknown opcode: abandon the instruction without writes.
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else if (bus.Op == OP_SW) begin
                    state_nxt_s = S_MEMWR;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (bus.MemReady) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (bus.MemReady) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                state_nxt_s = S_RTYPEWB;
            end
            S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP: begin
                state_nxt_s = S_FETCH;
            end
            default: begin
                // Unused codes recover to FETCH on the next edge.
                state_nxt_s = S_FETCH;
            end
        endcase
    end

    multicycle_decode u_decode (
        .state     (state_r),
        .mem_ready (bus.MemReady),
        .ctrl      (ctrl_dec_s)
    );

    // Force every control output low while reset is held.
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = CTRL_IDLE;
        end else begin
            ctrl_out_s = ctrl_dec_s;
        end
    end

    assign bus.PCWrite     = ctrl_out_s.pc_write;
    assign bus.PCWriteCond = ctrl_out_s.pc_write_cond;
    assign bus.IorD        = ctrl_out_s.ior_d;
    assign bus.MemRead     = ctrl_out_s.mem_read;
    assign bus.MemWrite    = ctrl_out_s.mem_write;
    assign bus.IRWrite     = ctrl_out_s.ir_write;
    assign bus.MemtoReg    = ctrl_out_s.mem_to_reg;
    assign bus.RegDst      = ctrl_out_s.reg_dst;
    assign bus.RegWrite    = ctrl_out_s.reg_write;
    assign bus.ALUSrcA     = ctrl_out_s.alu_src_a;
    assign bus.ALUSrcB     = ctrl_out_s.alu_src_b;
    assign bus.ALUOp       = ctrl_out_s.alu_op;
    assign bus.PCSource    = ctrl_out_s.pc_source;
    assign bus.State       = state_r;

endmodule
